csp_channel: RTL and testbench

- Synthesizable point-to-point CSP channel stage: one sender, one receiver, bundled-data request/acknowledge handshake.
- Every inter-block link in the PE uses it: depacketizer, filter/ifmap memories, multiplier, adder, split, accumulator and packetizer, with 64-bit links in the PE.
- Latches the sender's data word on request and presents it to the receiver.
- Completes the sender's handshake only after the receiver has acknowledged.

---
 rtl/csp_channel_pkg.sv | 6 +
 rtl/csp_channel_if.sv | 12 +
 rtl/csp_channel.sv | 50 +++++
 tb/tb_csp_channel.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/csp_channel_pkg.sv
// csp_channel_pkg: shared protocol, status and FSM state types for csp_channel
package csp_channel_pkg;
  typedef enum logic { P4_PHASE_BD = 1'b0, P2_PHASE_BD = 1'b1 } hs_protocol_e;
  typedef enum logic [1:0] { IDLE = 2'b00, SEND_PEND = 2'b01, ACK_PEND = 2'b10 } chan_status_e;
  typedef enum logic [1:0] { ST_IDLE, ST_PEND, ST_ACK } chan_state_e;
endpackage

// File: rtl/csp_channel_if.sv
// csp_channel_if: bundled-data req/ack link; slave is the channel stage, master its environment
interface csp_channel_if #(parameter int WIDTH = 64);
  logic s_req;
  logic [WIDTH-1:0] s_data;
  logic s_ack;
  logic r_req;
  logic [WIDTH-1:0] r_data;
  logic r_ack;
  logic [1:0] status;
  modport slave (input s_req, s_data, r_ack, output s_ack, r_req, r_data, status);
  modport master (output s_req, s_data, r_ack, input s_ack, r_req, r_data, status);
endinterface

// File: rtl/csp_channel.sv
// csp_channel: one-token CSP channel stage, 4-phase or 2-phase bundled data.
// Define CSP_CHANNEL_COUNT_EN to add the 32-bit xfer_count output.
module csp_channel import csp_channel_pkg::*; #(
  parameter int WIDTH = 64,
  parameter hs_protocol_e HS_PROTOCOL = P4_PHASE_BD
) (
  input logic clk,
  input logic rst,
`ifdef CSP_CHANNEL_COUNT_EN
  output logic [31:0] xfer_count,
`endif
  csp_channel_if.slave ch
);
  chan_state_e state;
  logic [WIDTH-1:0] data_q;
  logic four, take, done;
  assign four = HS_PROTOCOL == P4_PHASE_BD;
  assign take = state == ST_IDLE && (four ? ch.s_req : ch.s_req != ch.s_ack);
  assign done = state == ST_PEND && (four ? ch.r_ack : ch.r_ack == ch.r_req);
  assign ch.r_data = data_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      data_q <= '0;
      ch.r_req <= 1'b0;
      ch.s_ack <= 1'b0;
      ch.status <= IDLE;
    end else if (take) begin
      data_q <= ch.s_data;
      ch.r_req <= four ? 1'b1 : ~ch.r_req;
      state <= ST_PEND;
      ch.status <= SEND_PEND;
    end else if (done) begin
      // 4-phase lowers r_req and waits in ACK; 2-phase finishes on the s_ack toggle
      ch.r_req <= four ? 1'b0 : ch.r_req;
      ch.s_ack <= ~ch.s_ack;
      ch.status <= four ? ACK_PEND : IDLE;
      if (four) state <= ST_ACK;
      else state <= ST_IDLE;
    end else if (state == ST_ACK && !ch.s_req && !ch.r_ack) begin
      ch.s_ack <= 1'b0;
      state <= ST_IDLE;
      ch.status <= IDLE;
    end
`ifdef CSP_CHANNEL_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) xfer_count <= '0;
    else if (done) xfer_count <= xfer_count + 32'd1;
`endif
endmodule

// File: tb/tb_csp_channel.sv
// tb_csp_channel: scoreboard bench for a 4-phase and a 2-phase csp_channel instance
module tb_csp_channel;
  import csp_channel_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  csp_channel_if #(.WIDTH(64)) a ();
  csp_channel_if #(.WIDTH(64)) b ();
`ifdef CSP_CHANNEL_COUNT_EN
  logic [31:0] cnt4, cnt2;
`endif
  csp_channel #(.WIDTH(64), .HS_PROTOCOL(P4_PHASE_BD)) dut4 (
    .clk(clk), .rst(rst),
`ifdef CSP_CHANNEL_COUNT_EN
    .xfer_count(cnt4),
`endif
    .ch(a.slave));
  csp_channel #(.WIDTH(64), .HS_PROTOCOL(P2_PHASE_BD)) dut2 (
    .clk(clk), .rst(rst),
`ifdef CSP_CHANNEL_COUNT_EN
    .xfer_count(cnt2),
`endif
    .ch(b.slave));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int n4 = 0;
  int n2 = 0;
  logic [63:0] q4[$];
  logic [63:0] q2[$];
  logic exp_r2 = 1'b0;
  logic prev4 = 1'b0;
  logic prev2 = 1'b0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic sig(input int w);
    case (w)
      0: sig = a.r_req;
      1: sig = a.s_ack;
      2: sig = b.r_req;
      default: sig = b.s_ack;
    endcase
  endfunction
  task automatic wait_for(input int w, input logic v, input string n);
    for (int i = 0; i < 50; i++) begin
      if (sig(w) === v) return;
      tick();
    end
    total++;
    bad++;
    $display("FAIL %s timeout got=%b want=%b", n, sig(w), v);
  endtask
  task automatic send4(input logic [63:0] d, input int sd, input int rd);
    a.s_data = d;
    a.s_req = 1'b1;
    q4.push_back(d);
    wait_for(0, 1'b1, "p4_rreq_rise");
    repeat (rd) tick();
    a.r_ack = 1'b1;
    wait_for(1, 1'b1, "p4_sack_rise");
    n4++;
    repeat (sd) tick();
    a.s_req = 1'b0;
    repeat (rd) tick();
    a.r_ack = 1'b0;
    wait_for(1, 1'b0, "p4_sack_fall");
  endtask
  task automatic send2(input logic [63:0] d, input int rd);
    b.s_data = d;
    b.s_req = ~b.s_req;
    q2.push_back(d);
    exp_r2 = ~exp_r2;
    wait_for(2, exp_r2, "p2_rreq_toggle");
    repeat (rd) tick();
    b.r_ack = b.r_req;
    wait_for(3, b.s_req, "p2_sack_toggle");
    n2++;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (a.r_req && !prev4) begin
        chk("p4_token_expected", 64'(q4.size() != 0), 64'd1);
        if (q4.size() != 0) chk("p4_data", a.r_data, q4.pop_front());
        chk("p4_status_pend", 64'(a.status), 64'd1);
      end
      if (b.r_req != prev2) begin
        chk("p2_token_expected", 64'(q2.size() != 0), 64'd1);
        if (q2.size() != 0) chk("p2_data", b.r_data, q2.pop_front());
        chk("p2_status_pend", 64'(b.status), 64'd1);
      end
    end
    prev4 <= a.r_req;
    prev2 <= b.r_req;
  end
  initial begin
    logic [63:0] d;
    a.s_req = 0; a.s_data = '0; a.r_ack = 0;
    b.s_req = 0; b.s_data = '0; b.r_ack = 0;
    tick();
    chk("rst_sack", 64'(a.s_ack), 0);
    chk("rst_rreq", 64'(a.r_req), 0);
    chk("rst_rdata", a.r_data, 0);
    chk("rst_status", 64'(a.status), 0);
    chk("rst_p2_rreq", 64'(b.r_req), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send4(64'(i + 100), 0, 0);
`ifdef CSP_CHANNEL_COUNT_EN
    chk("count_five", 64'(cnt4), 64'(n4));
`endif
    d = 64'h0000_0011_1111_1111;
    a.s_data = d; a.s_req = 1; q4.push_back(d);
    tick();
    chk("single_rreq", 64'(a.r_req), 1);
    chk("single_rdata", a.r_data, d);
    chk("single_sack0", 64'(a.s_ack), 0);
    a.r_ack = 1;
    tick();
    chk("single_rreq_low", 64'(a.r_req), 0);
    chk("single_sack1", 64'(a.s_ack), 1);
    chk("single_status_ack", 64'(a.status), 2);
    a.s_req = 0; a.r_ack = 0;
    tick();
    chk("single_sack_clr", 64'(a.s_ack), 0);
    chk("single_status_idle", 64'(a.status), 0);
    a.r_ack = 1;
    tick();
    chk("idle_rack_ignored", 64'(a.status), 0);
    chk("idle_rack_no_sack", 64'(a.s_ack), 0);
    a.r_ack = 0;
    d = 64'hDEAD_BEEF_0BAD_F00D;
    a.s_data = d; a.s_req = 1; q4.push_back(d);
    tick();
    a.s_req = 0;
    a.s_data = '1;
    repeat (10) begin
      tick();
      chk("slow_status", 64'(a.status), 1);
      chk("slow_sack", 64'(a.s_ack), 0);
      chk("slow_rdata", a.r_data, d);
    end
    a.r_ack = 1;
    tick();
    chk("slow_sack1", 64'(a.s_ack), 1);
    a.r_ack = 0;
    tick();
    chk("slow_done", 64'(a.s_ack), 0);
    d = 64'h1234;
    a.s_data = d; a.s_req = 1; q4.push_back(d);
    tick();
    a.r_ack = 1;
    tick();
    a.r_ack = 0;
    repeat (3) begin
      tick();
      chk("asym_a_sack_held", 64'(a.s_ack), 1);
      chk("asym_a_no_relatch", 64'(a.status), 2);
    end
    a.s_req = 0;
    tick();
    chk("asym_a_sack_clr", 64'(a.s_ack), 0);
    d = 64'h5678;
    a.s_data = d; a.s_req = 1; q4.push_back(d);
    tick();
    a.r_ack = 1;
    tick();
    a.s_req = 0;
    repeat (3) begin
      tick();
      chk("asym_b_sack_held", 64'(a.s_ack), 1);
    end
    a.r_ack = 0;
    tick();
    chk("asym_b_sack_clr", 64'(a.s_ack), 0);
    d = 64'hA5A5;
    a.s_data = d; a.s_req = 1; q4.push_back(d);
    repeat (2) tick();
    chk("midpend_status", 64'(a.status), 1);
    #2 rst = 1'b1;
    n4 = 0;
    #1;
    chk("arst_rreq", 64'(a.r_req), 0);
    chk("arst_sack", 64'(a.s_ack), 0);
    chk("arst_rdata", a.r_data, 0);
    chk("arst_status", 64'(a.status), 0);
`ifdef CSP_CHANNEL_COUNT_EN
    chk("arst_count", 64'(cnt4), 0);
`endif
    a.s_req = 0;
    tick();
    rst = 1'b0;
    send4(64'h1, 0, 0);
    for (int i = 0; i < 30; i++)
      send4({$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
`ifdef CSP_CHANNEL_COUNT_EN
    chk("count_p4", 64'(cnt4), 64'(n4));
`endif
    send2(64'd1, 0);
    send2(64'd2, 1);
    send2(64'd3, 0);
    chk("p2_sack_eq_sreq", 64'(b.s_ack), 64'(b.s_req));
    chk("p2_rreq_parity", 64'(b.r_req), 64'(exp_r2));
    for (int i = 0; i < 20; i++) send2({$urandom, $urandom}, int'($urandom_range(0, 3)));
    chk("p2_final_ack", 64'(b.s_ack), 64'(b.s_req));
    chk("p2_status_idle", 64'(b.status), 0);
`ifdef CSP_CHANNEL_COUNT_EN
    chk("count_p2", 64'(cnt2), 64'(n2));
`endif
    repeat (2) tick();
    chk("p4_queue_drained", 64'(q4.size()), 0);
    chk("p2_queue_drained", 64'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
